// File: rtl/header_inserter.sv
// Avalon-ST header inserter: prepends a HEADER_SIZE-bit side-band header to each
// packet as HEADER_SIZE/DATA_WIDTH leading beats (MSB first), then passes payload through.
module header_inserter #(
  parameter int DATA_WIDTH  = 128,
  parameter int HEADER_SIZE = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [HEADER_SIZE-1:0] header_data,
  input  logic                   header_valid,
  output logic                   header_ack,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [15:0]            dropped_beats
);

  localparam int N  = HEADER_SIZE / DATA_WIDTH;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

  state_t                 state;
  logic [HEADER_SIZE-1:0] hdr_reg;
  logic [CW-1:0]          cnt;
  logic                   capture;
  logic                   drop;

  // The sop beat waits at the input (in_ready low) until a header is available;
  // the ack is the same-cycle acknowledge of the capture edge.
  assign capture    = rst_n && (state == IDLE) && in_valid && in_sop && header_valid;
  assign drop       = (state == IDLE) && in_valid && !in_sop;
  assign header_ack = capture;

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_data  = '0;
    case (state)
      IDLE:   in_ready = drop;
      HEADER: begin
        out_valid = 1'b1;
        out_sop   = (cnt == '0);
        out_data  = hdr_reg[HEADER_SIZE-1 -: DATA_WIDTH];
      end
      DATA: begin
        out_valid = in_valid;
        in_ready  = out_ready;
        out_eop   = in_eop;
        out_data  = in_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hdr_reg       <= '0;
      cnt           <= '0;
      dropped_beats <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (drop && dropped_beats != 16'hFFFF)
            dropped_beats <= dropped_beats + 16'd1;
          if (capture) begin
            hdr_reg <= header_data;
            cnt     <= '0;
            state   <= HEADER;
          end
        end
        HEADER: if (out_ready) begin
          hdr_reg <= hdr_reg << DATA_WIDTH;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) state <= DATA;
        end
        DATA: if (in_valid && out_ready && in_eop) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_header_inserter.sv
// Directed + randomized bench for header_inserter; expected output beats come from
// a packet-level model (header split MSB-first, then payload) held in a queue.
module tb_header_inserter;
  localparam int DW = 128;
  localparam int HS = 256;
  localparam int N  = HS / DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [HS-1:0] header_data;
  logic          header_valid;
  logic          header_ack;
  logic          in_valid, in_ready, in_sop, in_eop;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_sop, out_eop;
  logic [DW-1:0] out_data;
  logic [15:0]   dropped_beats;

  always #5 clk = ~clk;

  header_inserter #(.DATA_WIDTH(DW), .HEADER_SIZE(HS)) dut (
    .clk(clk), .rst_n(rst_n),
    .header_data(header_data), .header_valid(header_valid), .header_ack(header_ack),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .out_data(out_data), .dropped_beats(dropped_beats)
  );

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk = 0;
  int    n_pass = 0;

  task automatic chk(input string tag, input logic [HS-1:0] obs, input logic [HS-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [HS-1:0] rnd_hdr();
    logic [HS-1:0] r = '0;
    for (int k = 0; k < HS / 32; k++) r = (r << 32) | HS'($urandom);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_dw();
    logic [DW-1:0] r = '0;
    for (int k = 0; k < DW / 32; k++) r = (r << 32) | DW'($urandom);
    return r;
  endfunction

  // rmode: 0 = out_ready high, 1 = random out_ready, 2 = out_ready toggling 1,0,1,0...
  task automatic send_pkt(input logic [HS-1:0] h, input int n, input int rmode);
    logic [DW-1:0] pl[$];
    int            i = 0, guard = 0, acks = 0, seen = 0;
    bit            acc, stalled = 0, hv_drop;
    logic [DW:0]   held = '0;
    beat_t         e;
    for (int k = 0; k < N; k++) begin
      e.sop = (k == 0); e.eop = 1'b0; e.data = DW'(h >> ((N - 1 - k) * DW));
      exp_q.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      pl.push_back(rnd_dw());
      e.sop = 1'b0; e.eop = (k == n - 1); e.data = pl[k];
      exp_q.push_back(e);
    end
    header_data  = h;
    header_valid = 1'b1;
    while (i < n && guard < 200) begin
      in_valid = 1'b1; in_sop = (i == 0); in_eop = (i == n - 1); in_data = pl[i];
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (guard % 2 == 0);
      endcase
      @(negedge clk);
      if (guard == 0) begin
        chk("idle_gap_out_valid", out_valid, 0);
        chk("ack_first_cycle", header_ack, 1);
      end
      acks   += int'(header_ack);
      hv_drop = header_ack;
      if (stalled) chk("stall_hold", {out_sop, out_data}, held);
      stalled = out_valid && !out_ready;
      held    = {out_sop, out_data};
      acc     = in_valid && in_ready;
      if (acc && i == 0) chk("hdr_before_payload", seen, N);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat", {out_sop, out_eop, out_data}, e);
        end
        seen++;
      end
      @(posedge clk); #1;
      // Scramble the side-band header after capture: the packet must keep the old one.
      if (hv_drop) begin header_valid = 1'b0; header_data = rnd_hdr(); end
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b1;
    chk("pkt_done", guard < 200, 1);
    chk("ack_once", acks, 1);
    chk("exp_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [HS-1:0] h;
    header_data = '0; header_valid = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sop", out_sop, 0);
    chk("rst_out_eop", out_eop, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_dropped", dropped_beats, 0);
    in_valid = 1'b1; in_sop = 1'b1; header_valid = 1'b1; #1;
    chk("rst_no_ack", header_ack, 0);
    in_valid = 1'b0; in_sop = 1'b0; header_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // stray beats outside a packet are consumed and counted
    in_valid = 1'b1; in_sop = 1'b0;
    repeat (3) begin
      in_data = rnd_dw();
      @(negedge clk);
      chk("stray_in_ready", in_ready, 1);
      chk("stray_out_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("dropped_3", dropped_beats, 3);
    @(posedge clk); #1;

    send_pkt(rnd_hdr(), 3, 0);
    chk("dropped_still_3", dropped_beats, 3);
    send_pkt(rnd_hdr(), 2, 2);

    // sop waiting for a header: nothing moves, no ack
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_data = rnd_dw(); header_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("wait_in_ready", in_ready, 0);
      chk("wait_out_valid", out_valid, 0);
      chk("wait_no_ack", header_ack, 0);
      @(posedge clk); #1;
    end
    send_pkt(rnd_hdr(), 2, 0);

    // back-to-back single-beat packets
    send_pkt(rnd_hdr(), 1, 0);
    send_pkt(rnd_hdr(), 1, 0);

    for (int k = 0; k < 6; k++) send_pkt(rnd_hdr(), $urandom_range(1, 5), 1);

    // reset during the second payload beat
    h = rnd_hdr();
    header_data = h; header_valid = 1'b1; in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0;
    in_data = rnd_dw(); out_ready = 1'b1;
    @(negedge clk);
    chk("mid_ack", header_ack, 1);
    @(posedge clk); #1;
    header_valid = 1'b0;
    @(negedge clk);
    chk("mid_hdr_hi", {out_valid, out_sop, out_data}, {2'b11, h[HS-1 -: DW]});
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_hdr_lo", {out_valid, out_sop, out_data}, {2'b10, h[DW-1:0]});
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_pay0", {out_valid, out_sop, out_data}, {2'b10, in_data});
    @(posedge clk); #1;
    in_sop = 1'b0; in_data = rnd_dw();
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_dropped", dropped_beats, 0);
    @(posedge clk); #1;
    chk("mid_rst_idle", {out_valid, out_eop}, 0);
    in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    send_pkt(rnd_hdr(), 2, 0);

    // saturation of the drop counter
    in_valid = 1'b1; in_sop = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    chk("dropped_fffe", dropped_beats, 16'hFFFE);
    repeat (70000 - 65534) @(posedge clk);
    #1;
    chk("dropped_sat", dropped_beats, 16'hFFFF);
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
